cam_writer: RTL and testbench

- Write-side front end for the CAM; the CAM itself is the lookup/read side.
- Accepts 32-bit insert requests over a valid/ready handshake and probes the CAM with a READ to find an existing copy.
- On a miss, picks a slot (lowest free entry, else round-robin victim) and issues the CAM WRITE.
- Returns the resulting index over a valid/ready response channel.
- Sits between request producers and the CAM, and owns all CAM command/data/write_idx traffic.

---
 rtl/cam_pkg.sv | 28 ++
 rtl/cam_writer_if.sv | 41 ++++
 rtl/cam_free_pick.sv | 23 ++
 rtl/cam_writer.sv | 187 ++++++++++++++++++
 tb/tb_cam_writer.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/cam_pkg.sv
// Shared types for the CAM write-side front end: CAM command encoding,
// writer FSM states and a saturating counter helper.
package cam_pkg;

  // Command presented to the CAM alongside cam_enable.
  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } COMMAND;

  // Writer FSM states. The S_ prefix keeps these literals distinct from the
  // COMMAND literals, which share the same package scope.
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOOKUP = 2'd1,
    S_WRITE  = 2'd2,
    S_RESP   = 2'd3
  } cam_writer_state_e;

  localparam int DATA_W = 32;
  localparam int STAT_W = 16;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (v == {STAT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/cam_writer_if.sv
// Request/response and CAM-side signals of cam_writer.
// master = the writer itself, slave = producers/consumer/CAM around it.
interface cam_writer_if #(
  parameter int SIZE = 8
);
  import cam_pkg::*;

  localparam int IDXW = $clog2(SIZE);

  // request channel
  logic              req_valid;
  logic              req_ready;
  logic [DATA_W-1:0] req_data;
  // response channel
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDXW-1:0]   rsp_idx;
  logic              rsp_hit;
  logic              rsp_evict;
  logic [IDXW:0]     occupancy;
  // CAM command side
  logic              cam_enable;
  COMMAND            cam_command;
  logic [DATA_W-1:0] cam_data;
  logic [IDXW-1:0]   cam_write_idx;
  logic [IDXW-1:0]   cam_read_idx;
  logic              cam_hit;

  modport master (
    input  req_valid, req_data, rsp_ready, cam_read_idx, cam_hit,
    output req_ready, rsp_valid, rsp_idx, rsp_hit, rsp_evict, occupancy,
           cam_enable, cam_command, cam_data, cam_write_idx
  );

  modport slave (
    output req_valid, req_data, rsp_ready, cam_read_idx, cam_hit,
    input  req_ready, rsp_valid, rsp_idx, rsp_hit, rsp_evict, occupancy,
           cam_enable, cam_command, cam_data, cam_write_idx
  );

endinterface

// File: rtl/cam_free_pick.sv
// Priority encoder: lowest index whose valid bit is clear.
module cam_free_pick #(
  parameter int SIZE = 8,
  parameter int IDXW = $clog2(SIZE)
) (
  input  logic [SIZE-1:0] valid,
  output logic [IDXW-1:0] free_idx,
  output logic            any_free
);

  // Scan high to low so the last assignment wins with the lowest free slot.
  always_comb begin
    free_idx = '0;
    any_free = 1'b0;
    for (int i = SIZE - 1; i >= 0; i--) begin
      if (!valid[i]) begin
        free_idx = IDXW'(i);
        any_free = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cam_writer.sv
// Write-side front end for the CAM. Each request is probed with a CAM READ;
// on a miss a slot is chosen (lowest free, else round-robin victim) and a
// CAM WRITE is issued. The resulting index is returned on the response channel.
// Optional build macro: CAM_WRITER_STATS_EN adds saturating hit/miss counters.
module cam_writer
  import cam_pkg::*;
#(
  parameter int SIZE = 8
) (
  input  logic         clock,
  input  logic         reset,
  cam_writer_if.master bus
`ifdef CAM_WRITER_STATS_EN
  ,
  output logic [STAT_W-1:0] hit_count,
  output logic [STAT_W-1:0] miss_count
`endif
);

  localparam int IDXW = $clog2(SIZE);

  cam_writer_state_e r_state;
  cam_writer_state_e w_state_next;

  logic [DATA_W-1:0] r_data;
  logic [SIZE-1:0]   r_valid;
  logic [IDXW-1:0]   r_vp;
  logic [IDXW:0]     r_occ;
  logic [IDXW-1:0]   r_target;
  logic              r_evict;
  logic [IDXW-1:0]   r_rsp_idx;
  logic              r_rsp_hit;

  logic [IDXW-1:0]   w_free_idx;
  logic              w_any_free;
  logic              w_rsp_fire;

  cam_free_pick #(
    .SIZE (SIZE),
    .IDXW (IDXW)
  ) u_free_pick (
    .valid    (r_valid),
    .free_idx (w_free_idx),
    .any_free (w_any_free)
  );

  assign w_rsp_fire = (r_state == S_RESP) && bus.rsp_ready;

  // FSM state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and per-state handshake/CAM command outputs.
  always_comb begin
    w_state_next    = r_state;
    bus.req_ready   = 1'b0;
    bus.rsp_valid   = 1'b0;
    bus.cam_enable  = 1'b0;
    bus.cam_command = READ;
    bus.cam_data    = '0;
    case (r_state)
      S_IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          w_state_next = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        bus.cam_enable  = 1'b1;
        bus.cam_command = READ;
        bus.cam_data    = r_data;
        w_state_next    = bus.cam_hit ? S_RESP : S_WRITE;
      end
      S_WRITE: begin
        bus.cam_enable  = 1'b1;
        bus.cam_command = WRITE;
        bus.cam_data    = r_data;
        w_state_next    = S_RESP;
      end
      S_RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Capture the request value on acceptance; it drives cam_data afterwards.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_data <= '0;
    end else if (r_state == S_IDLE && bus.req_valid) begin
      r_data <= bus.req_data;
    end
  end

  // Resolve the lookup: keep the CAM's index on a hit, otherwise choose the
  // write target. The victim pointer only advances when the table is full.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_target  <= '0;
      r_evict   <= 1'b0;
      r_rsp_idx <= '0;
      r_rsp_hit <= 1'b0;
      r_vp      <= '0;
    end else if (r_state == S_LOOKUP) begin
      if (bus.cam_hit) begin
        r_rsp_idx <= bus.cam_read_idx;
        r_rsp_hit <= 1'b1;
        r_evict   <= 1'b0;
      end else if (w_any_free) begin
        r_target  <= w_free_idx;
        r_rsp_idx <= w_free_idx;
        r_rsp_hit <= 1'b0;
        r_evict   <= 1'b0;
      end else begin
        r_target  <= r_vp;
        r_rsp_idx <= r_vp;
        r_rsp_hit <= 1'b0;
        r_evict   <= 1'b1;
        r_vp      <= (r_vp == IDXW'(SIZE - 1)) ? '0 : r_vp + 1'b1;
      end
    end
  end

  // Local shadow of CAM occupancy: one valid bit per entry, set on WRITE.
  generate
    for (genvar gi = 0; gi < SIZE; gi++) begin : g_valid
      // Mark entry gi as occupied when it is the write target.
      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          r_valid[gi] <= 1'b0;
        end else if (r_state == S_WRITE && r_target == IDXW'(gi)) begin
          r_valid[gi] <= 1'b1;
        end
      end
    end
  endgenerate

  // Count newly filled entries; an eviction reuses a slot so the count holds.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_occ <= '0;
    end else if (r_state == S_WRITE && !r_evict && r_occ != (IDXW+1)'(SIZE)) begin
      r_occ <= r_occ + 1'b1;
    end
  end

  assign bus.cam_write_idx = r_target;
  assign bus.rsp_idx       = r_rsp_idx;
  assign bus.rsp_hit       = r_rsp_hit;
  assign bus.rsp_evict     = r_evict;
  assign bus.occupancy     = r_occ;

`ifdef CAM_WRITER_STATS_EN
  logic [STAT_W-1:0] r_hit_count;
  logic [STAT_W-1:0] r_miss_count;

  // Tally completed responses by outcome, sticking at the maximum.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_hit_count  <= '0;
      r_miss_count <= '0;
    end else if (w_rsp_fire) begin
      if (r_rsp_hit) begin
        r_hit_count <= sat_inc(r_hit_count);
      end else begin
        r_miss_count <= sat_inc(r_miss_count);
      end
    end
  end

  assign hit_count  = r_hit_count;
  assign miss_count = r_miss_count;
`else
  logic w_unused;
  assign w_unused = w_rsp_fire;
`endif

endmodule

// File: tb/tb_cam_writer.sv
// Directed bench for cam_writer with a behavioural CAM attached.
`timescale 1ns/1ps
module tb_cam_writer;
  import cam_pkg::*;

  localparam int SIZE = 8;
  localparam int IDXW = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cam_writer_if #(.SIZE(SIZE)) bus ();

`ifdef CAM_WRITER_STATS_EN
  logic [15:0] hit_count;
  logic [15:0] miss_count;
`endif

  cam_writer #(.SIZE(SIZE)) dut (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus)
`ifdef CAM_WRITER_STATS_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  // Behavioural CAM: combinational lowest-index match, write on clock edge,
  // cleared by the same reset as the writer.
  logic [31:0]     m_data [SIZE];
  logic [SIZE-1:0] m_valid;
  int              wr_count;

  always_comb begin
    bus.cam_hit      = 1'b0;
    bus.cam_read_idx = '0;
    for (int i = SIZE - 1; i >= 0; i--) begin
      if (m_valid[i] && m_data[i] == bus.cam_data) begin
        bus.cam_hit      = 1'b1;
        bus.cam_read_idx = IDXW'(i);
      end
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid  <= '0;
      wr_count <= 0;
    end else if (bus.cam_enable && bus.cam_command == WRITE) begin
      m_data[bus.cam_write_idx]  <= bus.cam_data;
      m_valid[bus.cam_write_idx] <= 1'b1;
      wr_count                   <= wr_count + 1;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One insert transaction; hold = cycles to stall rsp_ready once valid.
  task automatic insert(input logic [31:0] d, input int e_idx, input int e_hit,
                        input int e_evict, input int e_lat, input int e_occ,
                        input int hold);
    int n;
    int w0;
    logic [IDXW-1:0] idx0;
    @(negedge clk);
    chk("req_ready_idle", 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1;
    bus.req_data  = d;
    w0 = wr_count;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_data  = '0;
    n = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin
        n = c;
        break;
      end
    end
    chk("latency", 32'(n), 32'(e_lat));
    chk("rsp_idx", 32'(bus.rsp_idx), 32'(e_idx));
    chk("rsp_hit", 32'(bus.rsp_hit), 32'(e_hit));
    chk("rsp_evict", 32'(bus.rsp_evict), 32'(e_evict));
    chk("req_ready_busy", 32'(bus.req_ready), 32'd0);
    idx0 = bus.rsp_idx;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      chk("hold_rsp_idx", 32'(bus.rsp_idx), 32'(idx0));
      chk("hold_req_ready", 32'(bus.req_ready), 32'd0);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
    chk("cam_writes", 32'(wr_count - w0), (e_hit != 0) ? 32'd0 : 32'd1);
    chk("occupancy", 32'(bus.occupancy), 32'(e_occ));
    chk("rsp_valid_drop", 32'(bus.rsp_valid), 32'd0);
    $display("insert data=0x%08h idx=%0d hit=%0d evict=%0d lat=%0d occ=%0d",
             d, idx0, e_hit, e_evict, n, bus.occupancy);
  endtask

  // Reset values of every writer output.
  task automatic chk_reset_outputs(input string pfx);
    chk({pfx, "_req_ready"}, 32'(bus.req_ready), 32'd1);
    chk({pfx, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
    chk({pfx, "_rsp_idx"}, 32'(bus.rsp_idx), 32'd0);
    chk({pfx, "_rsp_hit"}, 32'(bus.rsp_hit), 32'd0);
    chk({pfx, "_rsp_evict"}, 32'(bus.rsp_evict), 32'd0);
    chk({pfx, "_occupancy"}, 32'(bus.occupancy), 32'd0);
    chk({pfx, "_cam_enable"}, 32'(bus.cam_enable), 32'd0);
    chk({pfx, "_cam_command"}, 32'(bus.cam_command), 32'd0);
    chk({pfx, "_cam_data"}, bus.cam_data, 32'd0);
    chk({pfx, "_cam_write_idx"}, 32'(bus.cam_write_idx), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid = 1'b0;
    bus.req_data  = '0;
    bus.rsp_ready = 1'b0;
    rst_n         = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1'b1;

    // First insert misses into slot 0; a repeat hits with no CAM write.
    insert(32'hDEAD_0000, 0, 0, 0, 3, 1, 0);
    insert(32'hDEAD_0000, 0, 1, 0, 2, 1, 0);

    // Fill all eight slots in order from empty.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      insert(32'(i + 1), i, 0, 0, 3, i + 1, 0);
    end
    // Full table: 0x9..0x10 evict round-robin from slot 0, then wrap to 0.
    for (int k = 0; k < 8; k++) begin
      insert(32'(9 + k), k, 0, 1, 3, 8, 0);
    end
    insert(32'h11, 0, 0, 1, 3, 8, 0);

    // 0xA still sits in slot 1; stall the response for 5 cycles.
    insert(32'hA, 1, 1, 0, 2, 8, 5);

    // Reset while the CAM WRITE for 0x55 is on the bus (victim slot 1).
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_data  = 32'h55;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_data  = '0;
    @(negedge clk);
    @(negedge clk);
    chk("wr_cam_enable", 32'(bus.cam_enable), 32'd1);
    chk("wr_cam_command", 32'(bus.cam_command), 32'd1);
    chk("wr_cam_write_idx", 32'(bus.cam_write_idx), 32'd1);
    chk("wr_cam_data", bus.cam_data, 32'h55);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    insert(32'h55, 0, 0, 0, 3, 1, 0);

`ifdef CAM_WRITER_STATS_EN
    do_reset();
    #1;
    chk("stats_hit_rst", 32'(hit_count), 32'd0);
    chk("stats_miss_rst", 32'(miss_count), 32'd0);
    insert(32'h100, 0, 0, 0, 3, 1, 0);
    insert(32'h101, 1, 0, 0, 3, 2, 0);
    insert(32'h102, 2, 0, 0, 3, 3, 0);
    insert(32'h100, 0, 1, 0, 2, 3, 0);
    insert(32'h102, 2, 1, 0, 2, 3, 0);
    chk("stats_hit", 32'(hit_count), 32'd2);
    chk("stats_miss", 32'(miss_count), 32'd3);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
